// File: rtl/match_controller.sv
// Two-player match sequencer: idle, rally, post-point pause and match-over,
// with per-player scores, seven-segment score decodes and a winner flag.
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win_l,
  input  logic       win_r,
  input  logic       start,
  output logic       play_en,
  output logic       field_reset,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic [6:0] hex_l,
  output logic [6:0] hex_r,
  output logic [1:0] winner
);

  localparam logic [2:0] WIN_VAL   = 3'(WIN_SCORE);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HOLD = 2'b10,
    OVER = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] score_l_q, score_l_d;
  logic [2:0] score_r_q, score_r_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] winner_q, winner_d;
  logic       field_reset_q, field_reset_d;

  function automatic logic [6:0] seg_decode(input logic [2:0] value);
    logic [6:0] seg;
    case (value)
      3'd0:    seg = 7'b1000000;
      3'd1:    seg = 7'b1111001;
      3'd2:    seg = 7'b0100100;
      3'd3:    seg = 7'b0110000;
      3'd4:    seg = 7'b0011001;
      3'd5:    seg = 7'b0010010;
      3'd6:    seg = 7'b0000010;
      default: seg = 7'b1111000;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      score_l_q     <= 3'd0;
      score_r_q     <= 3'd0;
      hold_cnt_q    <= 8'd0;
      winner_q      <= 2'b00;
      field_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      hold_cnt_q    <= hold_cnt_d;
      winner_q      <= winner_d;
      field_reset_q <= field_reset_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    hold_cnt_d = hold_cnt_q;
    winner_d   = winner_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        // A simultaneous score from both sides is a replayed point.
        if (win_l && win_r) begin
          state_d    = HOLD;
          hold_cnt_d = 8'd0;
        end else if (win_l) begin
          score_l_d = score_l_q + 3'd1;
          if (score_l_d == WIN_VAL) begin
            state_d  = OVER;
            winner_d = 2'b01;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = 8'd0;
          end
        end else if (win_r) begin
          score_r_d = score_r_q + 3'd1;
          if (score_r_d == WIN_VAL) begin
            state_d  = OVER;
            winner_d = 2'b10;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = 8'd0;
          end
        end
      end

      HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = PLAY;
        end
      end

      OVER: begin
        if (start) begin
          state_d   = PLAY;
          score_l_d = 3'd0;
          score_r_d = 3'd0;
          winner_d  = 2'b00;
        end
      end

      default: state_d = IDLE;
    endcase

    // Pulse for the first cycle of every rally, whichever state it came from.
    field_reset_d = (state_d == PLAY) && (state_q != PLAY);
  end

  assign play_en     = (state_q == PLAY);
  assign field_reset = field_reset_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign winner      = winner_q;
  assign hex_l       = seg_decode(score_l_q);
  assign hex_r       = seg_decode(score_r_q);

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller with default parameters.
module tb_match_controller;

  logic       clk;
  logic       reset;
  logic       win_l;
  logic       win_r;
  logic       start;
  logic       play_en;
  logic       field_reset;
  logic [2:0] score_l;
  logic [2:0] score_r;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [0:7];

  match_controller #(.WIN_SCORE(7), .HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .win_l      (win_l),
    .win_r      (win_r),
    .start      (start),
    .play_en    (play_en),
    .field_reset(field_reset),
    .score_l    (score_l),
    .score_r    (score_r),
    .hex_l      (hex_l),
    .hex_r      (hex_r),
    .winner     (winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic r, input logic s);
    win_l = l;
    win_r = r;
    start = s;
    tick();
    win_l = 1'b0;
    win_r = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    seg_tab[0] = 7'b1000000;
    seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001;
    seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010;
    seg_tab[7] = 7'b1111000;

    reset = 1'b0;
    win_l = 1'b0;
    win_r = 1'b0;
    start = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_play_en", 16'(play_en), 16'd0);
    check("rst_field_reset", 16'(field_reset), 16'd0);
    check("rst_score_l", 16'(score_l), 16'd0);
    check("rst_score_r", 16'(score_r), 16'd0);
    check("rst_hex_l", 16'(hex_l), 16'(7'b1000000));
    check("rst_hex_r", 16'(hex_r), 16'(7'b1000000));
    check("rst_winner", 16'(winner), 16'd0);
    $display("step reset: play_en=%0b score=%0d/%0d", play_en, score_l, score_r);

    reset = 1'b1;
    tick();

    // Win pulses in IDLE are ignored
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("idle_win_score_l", 16'(score_l), 16'd0);
    check("idle_win_score_r", 16'(score_r), 16'd0);
    check("idle_win_play_en", 16'(play_en), 16'd0);
    $display("step idle wins: score=%0d/%0d", score_l, score_r);

    // Start
    pulse(1'b0, 1'b0, 1'b1);
    check("start_field_reset", 16'(field_reset), 16'd1);
    check("start_play_en", 16'(play_en), 16'd1);
    tick();
    check("start_fr_low", 16'(field_reset), 16'd0);
    check("start_play_en2", 16'(play_en), 16'd1);
    check("start_hex_l", 16'(hex_l), 16'(7'b1000000));
    $display("step start: play_en=%0b field_reset=%0b", play_en, field_reset);

    // Left point, then start/win_r during HOLD are ignored
    pulse(1'b1, 1'b0, 1'b0);
    check("pt_l_score_l", 16'(score_l), 16'd1);
    check("pt_l_hex_l", 16'(hex_l), 16'(7'b1111001));
    check("pt_l_play_en", 16'(play_en), 16'd0);
    pulse(1'b0, 1'b1, 1'b1);
    check("hold_ign_score_r", 16'(score_r), 16'd0);
    check("hold_ign_score_l", 16'(score_l), 16'd1);
    check("hold_ign_play_en", 16'(play_en), 16'd0);
    tick();
    check("hold_c3_play_en", 16'(play_en), 16'd0);
    tick();
    check("hold_c4_play_en", 16'(play_en), 16'd0);
    check("hold_c4_fr", 16'(field_reset), 16'd0);
    tick();
    check("hold_exit_play_en", 16'(play_en), 16'd1);
    check("hold_exit_fr", 16'(field_reset), 16'd1);
    tick();
    check("hold_exit_fr_low", 16'(field_reset), 16'd0);
    $display("step left point: score=%0d/%0d play_en=%0b", score_l, score_r, play_en);

    // Simultaneous point is replayed
    pulse(1'b1, 1'b1, 1'b0);
    check("both_score_l", 16'(score_l), 16'd1);
    check("both_score_r", 16'(score_r), 16'd0);
    check("both_play_en", 16'(play_en), 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("both_hold_play_en", 16'(play_en), 16'd0);
    end
    tick();
    check("both_exit_play_en", 16'(play_en), 16'd1);
    check("both_exit_fr", 16'(field_reset), 16'd1);
    $display("step replay: score=%0d/%0d", score_l, score_r);

    // Right player wins with seven points
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b0, 1'b1, 1'b0);
      check("r_score_r", 16'(score_r), 16'(i));
      check("r_hex_r", 16'(hex_r), 16'(seg_tab[i]));
      check("r_play_en", 16'(play_en), 16'd0);
      if (i < 7) begin
        check("r_winner_none", 16'(winner), 16'd0);
        repeat (4) tick();
        check("r_replay_en", 16'(play_en), 16'd1);
      end
      $display("step right point %0d: score_r=%0d winner=%0b", i, score_r, winner);
    end
    check("over_winner", 16'(winner), 16'b10);
    check("over_score_l", 16'(score_l), 16'd1);

    // Match over: win pulses ignored
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    check("over_frz_score_l", 16'(score_l), 16'd1);
    check("over_frz_score_r", 16'(score_r), 16'd7);
    check("over_frz_winner", 16'(winner), 16'b10);
    check("over_frz_play_en", 16'(play_en), 16'd0);
    check("over_frz_fr", 16'(field_reset), 16'd0);
    $display("step over frozen: score=%0d/%0d winner=%0b", score_l, score_r, winner);

    // Restart from OVER
    pulse(1'b0, 1'b0, 1'b1);
    check("restart_score_l", 16'(score_l), 16'd0);
    check("restart_score_r", 16'(score_r), 16'd0);
    check("restart_winner", 16'(winner), 16'd0);
    check("restart_fr", 16'(field_reset), 16'd1);
    check("restart_play_en", 16'(play_en), 16'd1);
    tick();
    check("restart_fr_low", 16'(field_reset), 16'd0);
    $display("step restart: score=%0d/%0d winner=%0b", score_l, score_r, winner);

    // Left reaches 3, then asynchronous reset mid-HOLD
    for (int i = 1; i <= 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      if (i < 3) repeat (4) tick();
    end
    tick();
    check("pre_rst_score_l", 16'(score_l), 16'd3);
    check("pre_rst_hex_l", 16'(hex_l), 16'(7'b0110000));
    check("pre_rst_play_en", 16'(play_en), 16'd0);
    #2;
    reset = 1'b0;
    #1;
    check("arst_score_l", 16'(score_l), 16'd0);
    check("arst_hex_l", 16'(hex_l), 16'(7'b1000000));
    check("arst_play_en", 16'(play_en), 16'd0);
    check("arst_winner", 16'(winner), 16'd0);
    check("arst_fr", 16'(field_reset), 16'd0);
    $display("step async reset: score_l=%0d play_en=%0b", score_l, play_en);
    tick();
    reset = 1'b1;
    tick();

    // After release: back in IDLE until start
    pulse(1'b1, 1'b0, 1'b0);
    check("post_rst_score_l", 16'(score_l), 16'd0);
    check("post_rst_play_en", 16'(play_en), 16'd0);
    repeat (5) tick();
    check("post_rst_idle", 16'(play_en), 16'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("post_rst_start_en", 16'(play_en), 16'd1);
    check("post_rst_start_fr", 16'(field_reset), 16'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check("post_rst_point", 16'(score_l), 16'd1);
    $display("step post reset: score_l=%0d play_en=%0b", score_l, play_en);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter: WIN_SCORE, default 7, points needed to win a match (legal range 1..7).
REQ-002 Parameter: HOLD_CYCLES, default 4, length of the post-point pause in clock cycles (legal range 1..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 win_l  input  1  single-cycle pulse, left player scored (from the left win detector).
REQ-006 win_r  input  1  single-cycle pulse, right player scored (from the right win detector).
REQ-007 start  input  1  single-cycle pulse, begin a match or restart after match over.
REQ-008 play_en  output  1  high while rally inputs are to be accepted by the playfield.
REQ-009 field_reset  output  1  one-cycle pulse that recentres the playfield.
REQ-010 score_l  output  3  left player score, unsigned.
REQ-011 score_r  output  3  right player score, unsigned.
REQ-012 hex_l  output  7  active-low seven-segment pattern of score_l.
REQ-013 hex_r  output  7  active-low seven-segment pattern of score_r.
REQ-014 winner  output  2  00 none, 01 left, 10 right; 11 never driven.

Function
REQ-015 FSM states: IDLE, PLAY, HOLD, OVER; state, scores, hold counter, field_reset and winner SHALL all be registered.
REQ-016 IDLE: play_en=0. A start pulse SHALL move to PLAY; win_l/win_r SHALL be ignored.
REQ-017 PLAY: play_en=1. A win_l pulse alone SHALL increment score_l; a win_r pulse alone SHALL increment score_r; the new value is visible the cycle after the pulse.
REQ-018 PLAY: if the incremented score equals WIN_SCORE, the FSM SHALL go to OVER and set winner (01 left, 10 right) in the same edge; otherwise it SHALL go to HOLD with the hold counter loaded to 0.
REQ-019 PLAY: win_l and win_r in the same cycle SHALL leave both scores unchanged and go to HOLD (replayed point).
REQ-020 HOLD: play_en=0. The counter SHALL increment every cycle; on the cycle the counter equals HOLD_CYCLES-1, the FSM SHALL go to PLAY. HOLD therefore lasts exactly HOLD_CYCLES cycles.
REQ-021 field_reset SHALL be high for exactly the one cycle following every transition into PLAY (from IDLE, HOLD or OVER), and low otherwise.
REQ-022 OVER: play_en=0, scores and winner frozen; win pulses ignored. A start pulse SHALL clear both scores to 0, clear winner to 00 and go to PLAY.
REQ-023 start SHALL be ignored in PLAY and HOLD.
REQ-024 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-025 hex_l/hex_r SHALL be combinational decodes of score_l/score_r: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-026 play_en SHALL be a decode of the current state only (no input-to-output combinational path).

Reset
REQ-027 While reset=0: state=IDLE, score_l=score_r=0, hex_l=hex_r=1000000, winner=00, play_en=0, field_reset=0, hold counter=0, regardless of clk.
REQ-028 Reset asserted mid-match (any state, including mid-HOLD) SHALL abort immediately to the REQ-027 values; release SHALL return to IDLE, requiring a new start.

Verification
REQ-029 Reset then start pulse -> next cycle field_reset=1 and play_en=1; following cycle field_reset=0; scores 0, hex 1000000.
REQ-030 In PLAY, win_l pulse -> next cycle score_l=1, hex_l=1111001, play_en=0; play_en returns to 1 after 4 cycles (default HOLD_CYCLES) with field_reset pulsing once.
REQ-031 win_l and win_r in the same PLAY cycle -> scores unchanged, 4-cycle HOLD, field_reset pulse on re-entry to PLAY.
REQ-032 Seven win_r pulses, each issued in PLAY -> score_r=7, hex_r=1111000, winner=10, play_en stays 0; further win_l/win_r pulses leave all outputs unchanged; start -> scores 0, winner 00, field_reset pulse.
REQ-033 Win pulses and start pulses during HOLD, and win pulses in IDLE -> no score or state change.
REQ-034 reset driven low asynchronously mid-HOLD with score_l=3 -> outputs take REQ-027 values before the next clk edge; after release, win_l pulse has no effect until start.
